// File: rtl/ssd1306_pkg.sv
// Opcodes, enums and helpers shared by the SSD1306 command decoder.
// No latency or backpressure: constants and pure functions only.
package ssd1306_pkg;

    localparam int FB_BYTES = 1024;

    typedef enum logic [1:0] {AM_HORIZ = 2'd0, AM_VERT = 2'd1, AM_PAGE = 2'd2} addr_mode_t;
    typedef enum logic [1:0] {ST_CMD = 2'd0, ST_ARG1 = 2'd1, ST_ARG2 = 2'd2} parse_state_t;

    // Framebuffer pointer; packing page above col gives page*128 + col directly.
    typedef struct packed {
        logic [2:0] page;
        logic [6:0] col;
    } fb_ptr_t;

    localparam fb_ptr_t PTR_ZERO = '{page: 3'd0, col: 7'd0};
    localparam fb_ptr_t PTR_LAST = '{page: 3'd7, col: 7'd127};

    localparam logic [7:0] OP_SET_MODE    = 8'h20;
    localparam logic [7:0] OP_COL_WIN     = 8'h21;
    localparam logic [7:0] OP_PAGE_WIN    = 8'h22;
    localparam logic [7:0] OP_COL_LO_BASE = 8'h00;
    localparam logic [7:0] OP_COL_HI_BASE = 8'h10;
    localparam logic [7:0] OP_PAGE_BASE   = 8'hB0;
    localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OP_NORMAL      = 8'hA6;

    localparam logic [63:0] SKIP_OPS = {8'h81, 8'h8D, 8'hA8, 8'hD3,
                                        8'hD5, 8'hD9, 8'hDA, 8'hDB};

    function automatic logic is_skip_op(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (SKIP_OPS[i*8 +: 8] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic takes_arg(input logic [7:0] op);
        return (op == OP_SET_MODE) || (op == OP_COL_WIN) ||
               (op == OP_PAGE_WIN) || is_skip_op(op);
    endfunction

endpackage

// File: rtl/ssd1306_cmd_decoder_spi_byte_rx.sv
// SPI mode-0 byte receiver: 2-flop synchronizers, sclk rise detect, 8-bit shift, cs_n framing.
// byte_valid pulses 2 clk after stage 1 first sees the 8th sclk rise; no backpressure.
module spi_byte_rx (
    input  logic       clk,
    input  logic       greset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] cs_sync;
    logic [1:0] dc_sync;
    logic       sclk_prev;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       sclk_rise;

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;

    always_ff @(posedge clk) begin
        if (greset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            dc_sync   <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            dc_sync   <= {dc_sync[0], dc};
            sclk_prev <= sclk_sync[1];
        end
    end

    // Deselect only rewinds the bit counter; a stale shreg is fully overwritten by the next 8 bits.
    always_ff @(posedge clk) begin
        if (greset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, mosi_sync[1]};
                    byte_dc    <= dc_sync[1];
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_cmd_decoder.sv
// SSD1306 SPI command/data decoder driving byte writes into a 1024-byte framebuffer.
// fb_we pulses one clk after byte_valid (pins-to-strobe 3-4 clk); no backpressure, writes are never stalled.
module ssd1306_cmd_decoder
    import ssd1306_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic       clk,
    input  logic       greset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       display_on,
    output logic       invert
);

    // CLK_HZ is informational; all timing is counted in clk cycles.
    if (CLK_HZ <= 0) begin : g_clk_hz_unused
    end

    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_dc;
    logic         cmd_vld;
    logic         data_vld;

    parse_state_t state;
    parse_state_t state_nxt;
    logic [7:0]   pend_op;
    logic [6:0]   arg1;
    addr_mode_t   mode;
    fb_ptr_t      ptr;
    fb_ptr_t      ptr_adv;
    fb_ptr_t      win_start;
    fb_ptr_t      win_end;

    logic ld_mode, ld_col_win, ld_page_win, ld_page, ld_col_lo, ld_col_hi, ld_disp, ld_inv;

    spi_byte_rx u_rx (
        .clk        (clk),
        .greset     (greset),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .dc         (dc),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc)
    );

    assign cmd_vld  = byte_valid & ~byte_dc;
    assign data_vld = byte_valid &  byte_dc;

    always_ff @(posedge clk) begin
        if (greset) state <= ST_CMD;
        else        state <= state_nxt;
    end

    // Data bytes never move the parser, so a window sequence survives interleaved pixels.
    always_comb begin
        state_nxt = state;
        if (cmd_vld) begin
            case (state)
                ST_CMD:  if (takes_arg(byte_data)) state_nxt = ST_ARG1;
                ST_ARG1: state_nxt = (pend_op == OP_COL_WIN || pend_op == OP_PAGE_WIN) ? ST_ARG2 : ST_CMD;
                default: state_nxt = ST_CMD;
            endcase
        end
    end

    always_comb begin
        ld_mode     = 1'b0;
        ld_col_win  = 1'b0;
        ld_page_win = 1'b0;
        ld_page     = 1'b0;
        ld_col_lo   = 1'b0;
        ld_col_hi   = 1'b0;
        ld_disp     = 1'b0;
        ld_inv      = 1'b0;
        if (cmd_vld) begin
            case (state)
                ST_CMD: begin
                    ld_page   = byte_data[7:3] == OP_PAGE_BASE[7:3];
                    ld_col_lo = byte_data[7:4] == OP_COL_LO_BASE[7:4];
                    ld_col_hi = byte_data[7:3] == OP_COL_HI_BASE[7:3];
                    ld_disp   = byte_data[7:1] == OP_DISP_OFF[7:1];
                    ld_inv    = byte_data[7:1] == OP_NORMAL[7:1];
                end
                ST_ARG1: ld_mode = (pend_op == OP_SET_MODE) && (byte_data[1:0] != 2'd3);
                ST_ARG2: begin
                    ld_col_win  = pend_op == OP_COL_WIN;
                    ld_page_win = pend_op == OP_PAGE_WIN;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ptr_adv = ptr;
        case (mode)
            AM_HORIZ: begin
                if (ptr.col == win_end.col) begin
                    ptr_adv.col  = win_start.col;
                    ptr_adv.page = (ptr.page == win_end.page) ? win_start.page : ptr.page + 3'd1;
                end else begin
                    ptr_adv.col = ptr.col + 7'd1;
                end
            end
            AM_VERT: begin
                if (ptr.page == win_end.page) begin
                    ptr_adv.page = win_start.page;
                    ptr_adv.col  = (ptr.col == win_end.col) ? win_start.col : ptr.col + 7'd1;
                end else begin
                    ptr_adv.page = ptr.page + 3'd1;
                end
            end
            default: ptr_adv.col = ptr.col + 7'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            mode       <= AM_PAGE;
            ptr        <= PTR_ZERO;
            win_start  <= PTR_ZERO;
            win_end    <= PTR_LAST;
            pend_op    <= '0;
            arg1       <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
            display_on <= 1'b0;
            invert     <= 1'b0;
        end else begin
            fb_we <= data_vld;
            if (data_vld) begin
                fb_addr  <= ptr;
                fb_wdata <= byte_data;
                ptr      <= ptr_adv;
            end
            if (cmd_vld && state == ST_CMD)  pend_op <= byte_data;
            if (cmd_vld && state == ST_ARG1) arg1    <= byte_data[6:0];
            if (ld_mode) mode <= addr_mode_t'(byte_data[1:0]);
            if (ld_col_win) begin
                win_start.col <= arg1;
                win_end.col   <= byte_data[6:0];
                ptr.col       <= arg1;
            end
            if (ld_page_win) begin
                win_start.page <= arg1[2:0];
                win_end.page   <= byte_data[2:0];
                ptr.page       <= arg1[2:0];
            end
            if (ld_page)   ptr.page     <= byte_data[2:0];
            if (ld_col_lo) ptr.col[3:0] <= byte_data[3:0];
            if (ld_col_hi) ptr.col[6:4] <= byte_data[2:0];
            if (ld_disp)   display_on   <= byte_data[0];
            if (ld_inv)    invert       <= byte_data[0];
        end
    end

endmodule

// File: tb/tb_ssd1306_cmd_decoder.sv
// Directed bench for ssd1306_cmd_decoder: vector table of SPI bytes plus hand sequences.
// Expected strobes, addresses and flags are hand-computed from the addressing rules.
module tb_ssd1306_cmd_decoder;

    logic       clk = 1'b0;
    logic       greset = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b0;
    logic       dc = 1'b0;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       display_on;
    logic       invert;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int we_cnt = 0;
    int t_we = 0;
    int t_rise = 0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_data = '0;

    typedef struct {
        logic       rst;
        logic       dc;
        logic [7:0] b;
        logic       we;
        logic [9:0] addr;
    } vec_t;

    vec_t vecs[$];

    ssd1306_cmd_decoder dut (
        .clk        (clk),
        .greset     (greset),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .dc         (dc),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .display_on (display_on),
        .invert     (invert)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_we) begin
            we_cnt    <= we_cnt + 1;
            last_addr <= fb_addr;
            last_data <= fb_wdata;
            t_we      <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic [7:0] b,
                       input logic w, input logic [9:0] a);
        vec_t v;
        v.rst = r; v.dc = d; v.b = b; v.we = w; v.addr = a;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        greset = 1'b1;
        @(posedge clk); #1;
        greset = 1'b0;
    endtask

    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        cs_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mosi = b[7-i];
            dc   = d;
            sclk = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            sclk   = 1'b1;
            t_rise = cyc;
            repeat (3) @(posedge clk);
            #1;
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        send_bits(d, b, 8);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;

        // Group A: first data byte after reset
        add(1, 1, 8'h5A, 1, 10'd0);
        // Group B: horizontal mode in a 2x2 window at the bottom-right corner
        add(0, 0, 8'h20, 0, 0); add(0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h21, 0, 0); add(0, 0, 8'h7E, 0, 0); add(0, 0, 8'h7F, 0, 0);
        add(0, 0, 8'h22, 0, 0); add(0, 0, 8'h06, 0, 0); add(0, 0, 8'h07, 0, 0);
        add(0, 1, 8'h11, 1, 10'd894);
        add(0, 1, 8'h22, 1, 10'd895);
        add(0, 1, 8'h33, 1, 10'd1022);
        add(0, 1, 8'h44, 1, 10'd1023);
        add(0, 1, 8'h55, 1, 10'd894);
        // Group C: vertical mode, default windows
        add(1, 0, 8'h20, 0, 0); add(0, 0, 8'h01, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 8'h80 + 8'(i), 1, 10'(i * 128));
        add(0, 1, 8'h88, 1, 10'd1);
        // Group D: page mode with explicit page/col pointers
        add(1, 0, 8'hB3, 0, 0); add(0, 0, 8'h0F, 0, 0); add(0, 0, 8'h17, 0, 0);
        add(0, 1, 8'hC1, 1, 10'd511);
        add(0, 1, 8'hC2, 1, 10'd384);

        repeat (3) @(posedge clk);
        #1;
        greset = 1'b0;
        @(negedge clk);
        check("rst_fb_we",      32'(fb_we),      0);
        check("rst_fb_addr",    32'(fb_addr),    0);
        check("rst_fb_wdata",   32'(fb_wdata),   0);
        check("rst_display_on", 32'(display_on), 0);
        check("rst_invert",     32'(invert),     0);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            n0 = we_cnt;
            send_byte(vecs[k].dc, vecs[k].b);
            check($sformatf("vec%0d_pulses", k), 32'(we_cnt - n0), 32'(vecs[k].we));
            if (vecs[k].we) begin
                check($sformatf("vec%0d_addr", k), 32'(last_addr), 32'(vecs[k].addr));
                check($sformatf("vec%0d_data", k), 32'(last_data), 32'(vecs[k].b));
            end
        end

        // Strobe lands 4 clk edges after the 8th sclk rise is driven
        do_reset();
        n0 = we_cnt;
        send_byte(1'b1, 8'hC3);
        check("lat_pulses", 32'(we_cnt - n0), 1);
        check("lat_cycles", 32'(t_we - t_rise), 4);
        check("lat_addr",   32'(last_addr), 0);
        check("lat_data",   32'(last_data), 32'h0C3);

        // Partial byte discarded by cs_n deassertion, then a full 0xAF
        n0 = we_cnt;
        send_bits(1'b1, 8'hFF, 5);
        cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send_byte(1'b0, 8'hAF);
        check("cs_no_write",   32'(we_cnt - n0), 0);
        check("cs_display_on", 32'(display_on), 1);
        check("cs_invert",     32'(invert), 0);
        send_byte(1'b0, 8'hA7);
        check("invert_set", 32'(invert), 1);
        send_byte(1'b0, 8'hA6);
        check("invert_clr", 32'(invert), 0);

        // Reset between 0x21 and its first argument abandons the sequence
        send_byte(1'b0, 8'h21);
        do_reset();
        @(negedge clk);
        check("mid_rst_display_on", 32'(display_on), 0);
        n0 = we_cnt;
        send_byte(1'b1, 8'h05);
        check("mid_rst_pulses", 32'(we_cnt - n0), 1);
        check("mid_rst_addr",   32'(last_addr), 0);
        check("mid_rst_data",   32'(last_data), 32'h05);
        send_byte(1'b0, 8'h03);
        send_byte(1'b1, 8'h99);
        check("mid_rst_colcmd_addr", 32'(last_addr), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
